time_counter: RTL and testbench
===============================

# time_counter

- Parametrised successor to the single-rate seconds counter.
- Keeps an hours:minutes:seconds time-of-day value, advanced by a programmable prescaler on the single system clock.
- New over the previous generation:
  - `Slt` selects normal or fast (per-cycle) rate.
  - Synchronous load of a preset time.
  - Hold enable.
  - Configurable hour modulus.
  - Rollover and alarm pulses.
- Feeds the display/alarm logic of the timer subsystem.

## Interface
- `DIV`, default 50: clock cycles per second tick in normal mode; legal range 2..2^26.
- `HR_MOD`, default 24: hour modulus; legal range 2..32.
- `Clk` in 1: system clock, rising edge.
- `Reset` in 1: asynchronous, active-high; clears all state.
- `En` in 1: count enable; 0 freezes the prescaler and the time.
- `Slt` in 1: rate select; 0 = one second per `DIV` cycles, 1 = fast mode, one second per enabled cycle.
- `Load` in 1: synchronous preset strobe.
- `LdHr` in 5, `LdMin` in 6, `LdSec` in 6: preset values, sampled when `Load`=1.
- `AlmEn` in 1: alarm enable.
- `AlmHr` in 5, `AlmMin` in 6: alarm time.
- `Hr` out 5, `Min` out 6, `Sec` out 6: current time, registered.
- `Tick` out 1: one-cycle pulse, high in the first cycle a new `Sec` value is visible.
- `Wrap` out 1: one-cycle pulse on rollover from (`HR_MOD`-1):59:59 to 00:00:00.
- `Alarm` out 1: one-cycle pulse, see Operation.

## Operation
- **Reset values:** `Hr`=`Min`=`Sec`=0, prescaler=0, `Tick`=`Wrap`=`Alarm`=0.
- **Priority per cycle:** `Load` > `En`=0 hold > count.
- **Load:**
  - `Hr`, `Min`, `Sec` take `LdHr`, `LdMin`, `LdSec` on the next edge; the prescaler clears to 0.
  - Values ≥60 (min/sec) clamp to 59; `LdHr` ≥ `HR_MOD` clamps to `HR_MOD`-1.
  - A load never produces `Tick`, `Wrap` or `Alarm`, even when it coincides with an internal tick.
- **Prescaler, `Slt`=0:**
  - Counts 0..`DIV`-1 while `En`=1.
  - The internal tick fires when prescaler = `DIV`-1; the prescaler then wraps to 0.
- **Prescaler, `Slt`=1:**
  - The internal tick fires every enabled cycle; the prescaler is held at 0.
  - Switching `Slt` 1→0 therefore restarts a full `DIV` period.
  - Switching `Slt` 0→1 discards the partial count.
- **On internal tick:**
  - `Sec` increments modulo 60.
  - `Sec` 59→0 carries into `Min` (mod 60).
  - `Min` 59→0 carries into `Hr` (mod `HR_MOD`).
  - All three fields update on the same edge.
- **Alarm:** pulses when a tick (not a load) moves the time to `AlmHr`:`AlmMin`:00 while `AlmEn`=1. `AlmEn` is sampled in the tick cycle.
- **Out-of-range alarm values** (`AlmHr` ≥ `HR_MOD`, `AlmMin` ≥ 60): the alarm never fires.
- **Arithmetic:** all counters unsigned; the prescaler is $clog2(`DIV`) bits wide.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- **Latency:** the internal tick decision in cycle N → new time, `Tick`, `Wrap` and `Alarm` all visible after edge N+1, in the same cycle.
- **Tick spacing:** normal mode gives one `Tick` every `DIV` enabled cycles; fast mode gives `Tick` high continuously while `En`=1.
- **`En` low:** freezes the prescaler mid-count; counting resumes from the frozen value.
- **`Reset` mid-operation:** outputs clear immediately (asynchronously); counting restarts from prescaler 0 on the first edge after `Reset` falls.

## Structure
- Package `time_pkg` holds:
  - `SEC_MOD`=60, `MIN_MOD`=60.
  - Field widths `SEC_W`=6, `MIN_W`=6, `HR_W`=5.
  - The clamp function.
- Sub-module `mod_counter`:
  - Parameters: modulus, width.
  - Inputs: `inc`, `load`, load value.
  - Outputs: count, `carry` = `inc` & at max.
  - Instantiated three times (sec, min, hr) with the carry chained.
- The prescaler, `Slt` muxing and pulse registers live in `time_counter`.

## Test plan
- **Reset and first tick** (`DIV`=4): `Reset` pulse, then `En`=1, `Slt`=0 → `Sec`=1 with `Tick` high exactly 4 cycles after `Reset` falls; all outputs 0 during `Reset`.
- **Minute/hour/day rollover** (`HR_MOD`=24): load 23:59:58, `Slt`=1 → next cycle 23:59:59, then 00:00:00 with `Wrap`=1 for one cycle; `Hr` never shows 24.
- **Load clamp and priority:** load `LdHr`=30, `LdMin`=61, `LdSec`=63 in a tick cycle → 23:59:59, `Tick`=0, prescaler 0.
- **Hold and rate switch** (`DIV`=4): `En`=0 at prescaler 2 for 5 cycles → no change; resume → tick after 1 more cycle. Then `Slt` 0→1→0 → fast ticks each cycle, then a full 4-cycle gap.
- **Alarm:**
  - `AlmEn`=1, `AlmHr`=1, `AlmMin`=0; load 00:59:59; one tick → 01:00:00 with `Alarm` pulse.
  - Direct load of 01:00:00 → no `Alarm`.
  - `AlmHr`=25 → never fires.
- **Async reset mid-count:** assert `Reset` between edges at 12:34:56 → outputs 0 before the next `Clk` edge.

Source files
------------

// File: rtl/time_pkg.sv
// time_pkg: shared constants and helpers for the time-of-day counter.
//   SEC_MOD / MIN_MOD : moduli of the seconds and minutes fields
//   SEC_W / MIN_W / HR_W : field widths
//   clamp()           : saturate a preset value to a field's maximum
package time_pkg;

    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HR_W    = 5;

    // Returns v, or lim when v exceeds lim. Callers size the result down.
    function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/time_counter_if.sv
// time_counter_if: control, preset, alarm and time outputs of time_counter.
//   master modport : the controller driving En/Slt/Load/presets/alarm setup
//   slave modport  : the counter, driving Hr/Min/Sec and the Tick/Wrap/Alarm pulses
interface time_counter_if;
    import time_pkg::*;

    logic             En;
    logic             Slt;
    logic             Load;
    logic [HR_W-1:0]  LdHr;
    logic [MIN_W-1:0] LdMin;
    logic [SEC_W-1:0] LdSec;
    logic             AlmEn;
    logic [HR_W-1:0]  AlmHr;
    logic [MIN_W-1:0] AlmMin;
    logic [HR_W-1:0]  Hr;
    logic [MIN_W-1:0] Min;
    logic [SEC_W-1:0] Sec;
    logic             Tick;
    logic             Wrap;
    logic             Alarm;

    modport master (
        output En, Slt, Load, LdHr, LdMin, LdSec, AlmEn, AlmHr, AlmMin,
        input  Hr, Min, Sec, Tick, Wrap, Alarm
    );

    modport slave (
        input  En, Slt, Load, LdHr, LdMin, LdSec, AlmEn, AlmHr, AlmMin,
        output Hr, Min, Sec, Tick, Wrap, Alarm
    );

endinterface

// File: rtl/mod_counter.sv
// mod_counter: modulo-MOD counter with synchronous load.
//   clk, rst    : clock, asynchronous active-high reset (count -> 0)
//   inc_i       : advance by one (wraps MOD-1 -> 0)
//   load_i      : load ld_val_i; wins over inc_i
//   ld_val_i    : preset value (already in range)
//   count_o     : registered count
//   carry_o     : inc_i while at MOD-1, i.e. this field wraps on the next edge
module mod_counter #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [W-1:0] ld_val_i,
    output logic [W-1:0] count_o,
    output logic         carry_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_max;

    assign at_max  = (count_q == W'(MOD - 1));
    assign carry_o = inc_i & at_max;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = ld_val_i;
        end else if (inc_i) begin
            count_d = at_max ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/time_counter.sv
// time_counter: hours:minutes:seconds time-of-day counter.
//   DIV    : clock cycles per second in normal rate (2..2^26)
//   HR_MOD : hour modulus (2..32)
//   Clk    : system clock, rising edge
//   Reset  : asynchronous active-high reset, clears all state
//   bus    : time_counter_if.slave -- En/Slt/Load/presets/alarm setup in,
//            Hr/Min/Sec time and Tick/Wrap/Alarm one-cycle pulses out
module time_counter
    import time_pkg::*;
#(
    parameter int DIV    = 50,
    parameter int HR_MOD = 24
) (
    input  logic               Clk,
    input  logic               Reset,
    time_counter_if.slave      bus
);

    localparam int PW = $clog2(DIV);

    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic             tick_int;
    logic             presc_end;

    logic [SEC_W-1:0] sec_cnt;
    logic [MIN_W-1:0] min_cnt;
    logic [HR_W-1:0]  hr_cnt;
    logic             sec_carry;
    logic             min_carry;
    logic             hr_carry;

    logic [SEC_W-1:0] ld_sec;
    logic [MIN_W-1:0] ld_min;
    logic [HR_W-1:0]  ld_hr;

    logic [MIN_W-1:0] min_next;
    logic [HR_W-1:0]  hr_next;

    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             alarm_q, alarm_d;

    assign presc_end = (presc_q == PW'(DIV - 1));

    // Load suppresses the tick so that a preset never raises any pulse.
    assign tick_int = bus.En & ~bus.Load & (bus.Slt | presc_end);

    // Fast rate pins the prescaler at 0: leaving fast rate starts a full
    // period and entering it drops whatever partial count was there.
    always_comb begin
        presc_d = presc_q;
        if (bus.Load) begin
            presc_d = '0;
        end else if (bus.En) begin
            if (bus.Slt || presc_end) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    assign ld_sec = SEC_W'(clamp(8'(bus.LdSec), 8'(SEC_MOD - 1)));
    assign ld_min = MIN_W'(clamp(8'(bus.LdMin), 8'(MIN_MOD - 1)));
    assign ld_hr  = HR_W'(clamp(8'(bus.LdHr), 8'(HR_MOD - 1)));

    mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
        .clk      (Clk),
        .rst      (Reset),
        .inc_i    (tick_int),
        .load_i   (bus.Load),
        .ld_val_i (ld_sec),
        .count_o  (sec_cnt),
        .carry_o  (sec_carry)
    );

    mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
        .clk      (Clk),
        .rst      (Reset),
        .inc_i    (sec_carry),
        .load_i   (bus.Load),
        .ld_val_i (ld_min),
        .count_o  (min_cnt),
        .carry_o  (min_carry)
    );

    mod_counter #(.MOD(HR_MOD), .W(HR_W)) u_hr (
        .clk      (Clk),
        .rst      (Reset),
        .inc_i    (min_carry),
        .load_i   (bus.Load),
        .ld_val_i (ld_hr),
        .count_o  (hr_cnt),
        .carry_o  (hr_carry)
    );

    // Minute/hour values that follow a seconds wrap; only meaningful when
    // sec_carry is set. Out-of-range alarm settings can never equal them.
    assign min_next = min_carry ? '0 : min_cnt + MIN_W'(1);
    assign hr_next  = hr_carry  ? '0 : (min_carry ? hr_cnt + HR_W'(1) : hr_cnt);

    always_comb begin
        tick_d  = tick_int;
        wrap_d  = hr_carry;
        alarm_d = bus.AlmEn & sec_carry &
                  (min_next == bus.AlmMin) & (hr_next == bus.AlmHr);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            alarm_q <= alarm_d;
        end
    end

    assign bus.Sec   = sec_cnt;
    assign bus.Min   = min_cnt;
    assign bus.Hr    = hr_cnt;
    assign bus.Tick  = tick_q;
    assign bus.Wrap  = wrap_q;
    assign bus.Alarm = alarm_q;

endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: directed, table-driven check of time_counter with
// DIV=4, HR_MOD=24, plus hand-written reset sequences.
module tb_time_counter;

    logic Clk;
    logic Reset;

    time_counter_if bus();

    time_counter #(.DIV(4), .HR_MOD(24)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       ld, en, slt;
        logic [4:0] lh;
        logic [5:0] lm, ls;
        logic       almen;
        logic [4:0] almh;
        logic [5:0] almm;
        logic [4:0] eh;
        logic [5:0] em, es;
        logic       et, ew, ea;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic ld, en, slt,
                       input int lh, lm, ls,
                       input logic almen, input int almh, almm,
                       input int eh, em, es,
                       input logic et, ew, ea);
        vec_t v;
        v.ld = ld; v.en = en; v.slt = slt;
        v.lh = 5'(lh); v.lm = 6'(lm); v.ls = 6'(ls);
        v.almen = almen; v.almh = 5'(almh); v.almm = 6'(almm);
        v.eh = 5'(eh); v.em = 6'(em); v.es = 6'(es);
        v.et = et; v.ew = ew; v.ea = ea;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.Load  = v.ld;
        bus.En    = v.en;
        bus.Slt   = v.slt;
        bus.LdHr  = v.lh;
        bus.LdMin = v.lm;
        bus.LdSec = v.ls;
        bus.AlmEn = v.almen;
        bus.AlmHr = v.almh;
        bus.AlmMin = v.almm;
    endtask

    task automatic expect_state(input string name, input int h, m, s,
                                input logic t, w, a);
        checks++;
        if (bus.Hr !== 5'(h) || bus.Min !== 6'(m) || bus.Sec !== 6'(s) ||
            bus.Tick !== t || bus.Wrap !== w || bus.Alarm !== a) begin
            errors++;
            $display("FAIL %s: got %0d:%0d:%0d T%b W%b A%b, want %0d:%0d:%0d T%b W%b A%b",
                     name, bus.Hr, bus.Min, bus.Sec, bus.Tick, bus.Wrap, bus.Alarm,
                     h, m, s, t, w, a);
        end
    endtask

    initial begin
        // Reset state: Load/En asserted must have no effect while in reset.
        Reset = 1'b1;
        bus.Load = 1'b1; bus.En = 1'b1; bus.Slt = 1'b1;
        bus.LdHr = 5'd3; bus.LdMin = 6'd4; bus.LdSec = 6'd5;
        bus.AlmEn = 1'b0; bus.AlmHr = 5'd0; bus.AlmMin = 6'd0;
        #1;
        expect_state("reset_t0", 0, 0, 0, 0, 0, 0);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        expect_state("reset_held", 0, 0, 0, 0, 0, 0);

        // First tick, hold and rate switching.
        add(0,1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0);
        add(0,1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0);
        add(0,1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0);
        add(0,1,0, 0,0,0, 0,0,0, 0,0,1, 1,0,0);
        add(0,1,0, 0,0,0, 0,0,0, 0,0,1, 0,0,0);
        add(0,1,0, 0,0,0, 0,0,0, 0,0,1, 0,0,0);
        for (int i = 0; i < 5; i++)
            add(0,0,0, 0,0,0, 0,0,0, 0,0,1, 0,0,0);
        add(0,1,0, 0,0,0, 0,0,0, 0,0,1, 0,0,0);
        add(0,1,0, 0,0,0, 0,0,0, 0,0,2, 1,0,0);
        add(0,1,1, 0,0,0, 0,0,0, 0,0,3, 1,0,0);
        add(0,1,1, 0,0,0, 0,0,0, 0,0,4, 1,0,0);
        for (int i = 0; i < 3; i++)
            add(0,1,0, 0,0,0, 0,0,0, 0,0,4, 0,0,0);
        add(0,1,0, 0,0,0, 0,0,0, 0,0,5, 1,0,0);
        add(0,1,0, 0,0,0, 0,0,0, 0,0,5, 0,0,0);
        add(0,1,1, 0,0,0, 0,0,0, 0,0,6, 1,0,0);
        for (int i = 0; i < 3; i++)
            add(0,1,0, 0,0,0, 0,0,0, 0,0,6, 0,0,0);
        add(0,1,0, 0,0,0, 0,0,0, 0,0,7, 1,0,0);
        // Day rollover.
        add(1,1,1, 23,59,58, 0,0,0, 23,59,58, 0,0,0);
        add(0,1,1, 0,0,0,    0,0,0, 23,59,59, 1,0,0);
        add(0,1,1, 0,0,0,    0,0,0, 0,0,0,    1,1,0);
        add(0,1,1, 0,0,0,    0,0,0, 0,0,1,    1,0,0);
        // Clamped load in a tick cycle, prescaler restarts from 0.
        add(1,1,1, 30,61,63, 0,0,0, 23,59,59, 0,0,0);
        for (int i = 0; i < 3; i++)
            add(0,1,0, 0,0,0, 0,0,0, 23,59,59, 0,0,0);
        add(0,1,0, 0,0,0, 0,0,0, 0,0,0, 1,1,0);
        // Alarm.
        add(1,1,1, 0,59,59, 1,1,0,  0,59,59, 0,0,0);
        add(0,1,1, 0,0,0,   1,1,0,  1,0,0,   1,0,1);
        add(0,1,1, 0,0,0,   1,1,0,  1,0,1,   1,0,0);
        add(1,1,1, 1,0,0,   1,1,0,  1,0,0,   0,0,0);
        add(1,1,1, 0,59,59, 1,25,0, 0,59,59, 0,0,0);
        add(0,1,1, 0,0,0,   1,25,0, 1,0,0,   1,0,0);
        add(1,1,1, 0,59,59, 0,1,0,  0,59,59, 0,0,0);
        add(0,1,1, 0,0,0,   0,1,0,  1,0,0,   1,0,0);
        // Load wins over hold.
        add(1,0,0, 5,6,7,   0,0,0,  5,6,7,   0,0,0);

        // Release reset between edges together with the first vector.
        drive(vq[0]);
        Reset = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(posedge Clk); #1;
            expect_state($sformatf("vec%0d", i), vq[i].eh, vq[i].em, vq[i].es,
                         vq[i].et, vq[i].ew, vq[i].ea);
        end

        // Asynchronous reset mid-count at 12:34:56.
        bus.Load = 1'b1; bus.En = 1'b1; bus.Slt = 1'b0;
        bus.LdHr = 5'd12; bus.LdMin = 6'd34; bus.LdSec = 6'd56;
        bus.AlmEn = 1'b0;
        @(posedge Clk); #1;
        expect_state("preset_12_34_56", 12, 34, 56, 0, 0, 0);
        bus.Load = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #2;
        Reset = 1'b1;
        #1;
        expect_state("async_reset", 0, 0, 0, 0, 0, 0);
        @(posedge Clk); #1;
        expect_state("reset_hold", 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            expect_state($sformatf("restart%0d", i), 0, 0, 0, 0, 0, 0);
        end
        @(posedge Clk); #1;
        expect_state("restart_tick", 0, 0, 1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
